// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and sizing helper for the parametrised register file
package rf_pkg;

  localparam int RF_BUS_WIDTH  = 16;
  localparam int RF_ADDR_WIDTH = 3;

  function automatic int rf_num_regs(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits; a reservation on the same edge as a write wins
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int ADDR_WIDTH = RF_ADDR_WIDTH,
  localparam int NUM_REGS   = rf_num_regs(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic                  resv,
  input  logic [ADDR_WIDTH-1:0] resv_addr,
  input  logic [ADDR_WIDTH-1:0] rs_a,
  input  logic [ADDR_WIDTH-1:0] rs_b,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  busy_a,
  output logic                  busy_b,
  output logic                  busy_next_a,
  output logic                  busy_next_b
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_next;

  // Reservation is applied after the write-back clear so a newer producer keeps ownership.
  always_comb begin
    busy_next = busy_q;
    if (wr_en && wr_addr != '0) busy_next[wr_addr] = 1'b0;
    if (resv && resv_addr != '0) busy_next[resv_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_next;
  end

  assign busy_vec    = busy_q;
  assign busy_a      = busy_q[rs_a];
  assign busy_b      = busy_q[rs_b];
  assign busy_next_a = busy_next[rs_a];
  assign busy_next_b = busy_next[rs_b];

endmodule

// File: rtl/rf_param_top.sv
// rtl/rf_param_top.sv - register file with zero register, two registered read ports and optional write bypass
module rf_param_top
  import rf_pkg::*;
#(
  parameter  int BUS_WIDTH  = RF_BUS_WIDTH,
  parameter  int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter  int BYPASS     = 1,
  localparam int NUM_REGS   = rf_num_regs(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [BUS_WIDTH-1:0]  D,
  input  logic [ADDR_WIDTH-1:0] rsA,
  input  logic [ADDR_WIDTH-1:0] rsB,
  input  logic                  resv,
  input  logic [ADDR_WIDTH-1:0] resv_rd,
  output logic [BUS_WIDTH-1:0]  A,
  output logic [BUS_WIDTH-1:0]  B,
  output logic                  A_busy,
  output logic                  B_busy,
  output logic [NUM_REGS-1:0]   busy_vec
);

  logic [BUS_WIDTH-1:0] regs [NUM_REGS];
  logic                 wr_ok, hit_a, hit_b;
  logic                 busy_a, busy_b, busy_next_a, busy_next_b;
  logic [BUS_WIDTH-1:0] a_next, b_next;
  logic                 a_busy_next, b_busy_next;

  rf_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (regWrite),
    .wr_addr    (rd),
    .resv       (resv),
    .resv_addr  (resv_rd),
    .rs_a       (rsA),
    .rs_b       (rsB),
    .busy_vec   (busy_vec),
    .busy_a     (busy_a),
    .busy_b     (busy_b),
    .busy_next_a(busy_next_a),
    .busy_next_b(busy_next_b)
  );

  assign wr_ok = regWrite && (rd != '0);
  assign hit_a = (BYPASS != 0) && wr_ok && (rsA == rd);
  assign hit_b = (BYPASS != 0) && wr_ok && (rsB == rd);

  // A forwarded read also sees the busy bit as it will be after this edge.
  always_comb begin
    a_next      = (rsA == '0) ? '0 : regs[rsA];
    b_next      = (rsB == '0) ? '0 : regs[rsB];
    a_busy_next = busy_a;
    b_busy_next = busy_b;
    if (hit_a) begin
      a_next      = D;
      a_busy_next = busy_next_a;
    end
    if (hit_b) begin
      b_next      = D;
      b_busy_next = busy_next_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[rd] <= D;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A      <= '0;
      B      <= '0;
      A_busy <= 1'b0;
      B_busy <= 1'b0;
    end else begin
      A      <= a_next;
      B      <= b_next;
      A_busy <= a_busy_next;
      B_busy <= b_busy_next;
    end
  end

endmodule

// File: tb/tb_rf_param_top.sv
// tb/tb_rf_param_top.sv - scoreboard bench: default bypass instance and a 32-bit/16-entry no-bypass instance
module tb_rf_param_top;

  typedef struct packed {
    logic        we;
    logic [3:0]  rd;
    logic [31:0] d;
    logic [3:0]  rsa;
    logic [3:0]  rsb;
    logic        resv;
    logic [3:0]  rr;
  } stim_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        ab;
    logic        bb;
    logic [15:0] bv;
  } exp_t;

  logic clk, rst_n;

  logic        we0, resv0, ab0, bb0;
  logic [2:0]  rd0, rsa0, rsb0, rr0;
  logic [15:0] d0, a0, b0;
  logic [7:0]  bv0;

  logic        we1, resv1, ab1, bb1;
  logic [3:0]  rd1, rsa1, rsb1, rr1;
  logic [31:0] d1, a1, b1;
  logic [15:0] bv1;

  rf_param_top dut0 (
    .clk(clk), .rst_n(rst_n), .regWrite(we0), .rd(rd0), .D(d0), .rsA(rsa0), .rsB(rsb0),
    .resv(resv0), .resv_rd(rr0), .A(a0), .B(b0), .A_busy(ab0), .B_busy(bb0), .busy_vec(bv0)
  );

  rf_param_top #(.BUS_WIDTH(32), .ADDR_WIDTH(4), .BYPASS(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .regWrite(we1), .rd(rd1), .D(d1), .rsA(rsa1), .rsB(rsb1),
    .resv(resv1), .resv_rd(rr1), .A(a1), .B(b1), .A_busy(ab1), .B_busy(bb1), .busy_vec(bv1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  exp_t q0[$];
  exp_t q1[$];

  logic [31:0] mem  [2][16];
  logic        bsy  [2][16];
  int          bypass_cfg [2] = '{1, 0};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", nm, got, expv, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 16; i++) begin
        mem[k][i] = '0;
        bsy[k][i] = 1'b0;
      end
  endtask

  // Reference: read the pre-edge state (or forwarded data), then apply write, then reservation.
  task automatic model_step(input int k, input stim_t s, output exp_t e);
    logic wr_ok, rs_ok;
    wr_ok = s.we && (s.rd != 0);
    rs_ok = s.resv && (s.rr != 0);
    if (bypass_cfg[k] != 0 && wr_ok && s.rsa == s.rd) begin
      e.a = s.d; e.ab = rs_ok && (s.rr == s.rd);
    end else begin
      e.a = mem[k][s.rsa]; e.ab = bsy[k][s.rsa];
    end
    if (bypass_cfg[k] != 0 && wr_ok && s.rsb == s.rd) begin
      e.b = s.d; e.bb = rs_ok && (s.rr == s.rd);
    end else begin
      e.b = mem[k][s.rsb]; e.bb = bsy[k][s.rsb];
    end
    if (wr_ok) begin
      mem[k][s.rd] = s.d;
      bsy[k][s.rd] = 1'b0;
    end
    if (rs_ok) bsy[k][s.rr] = 1'b1;
    e.bv = '0;
    for (int i = 0; i < 16; i++) e.bv[i] = bsy[k][i];
  endtask

  function automatic stim_t mk(input logic we, input int rd, input logic [31:0] d,
                               input int rsa, input int rsb, input logic resv, input int rr);
    stim_t s;
    s.we = we; s.rd = rd[3:0]; s.d = d; s.rsa = rsa[3:0]; s.rsb = rsb[3:0];
    s.resv = resv; s.rr = rr[3:0];
    return s;
  endfunction

  function automatic stim_t narrow(input stim_t s);
    stim_t n;
    n = s;
    n.rd[3] = 1'b0; n.rsa[3] = 1'b0; n.rsb[3] = 1'b0; n.rr[3] = 1'b0;
    n.d[31:16] = '0;
    return n;
  endfunction

  task automatic drive_raw(input stim_t s0, input stim_t s1);
    we0 = s0.we; rd0 = s0.rd[2:0]; d0 = s0.d[15:0]; rsa0 = s0.rsa[2:0]; rsb0 = s0.rsb[2:0];
    resv0 = s0.resv; rr0 = s0.rr[2:0];
    we1 = s1.we; rd1 = s1.rd; d1 = s1.d; rsa1 = s1.rsa; rsb1 = s1.rsb;
    resv1 = s1.resv; rr1 = s1.rr;
  endtask

  task automatic do_cycle(input stim_t s0, input stim_t s1);
    exp_t e;
    stim_t n0;
    n0 = narrow(s0);
    @(negedge clk);
    drive_raw(n0, s1);
    model_step(0, n0, e); q0.push_back(e);
    model_step(1, s1, e); q1.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_A0"}, {16'b0, a0}, 32'h0);
    chk({tag, "_B0"}, {16'b0, b0}, 32'h0);
    chk({tag, "_busy0"}, {22'b0, ab0, bb0, bv0}, 32'h0);
    chk({tag, "_A1"}, a1, 32'h0);
    chk({tag, "_B1"}, b1, 32'h0);
    chk({tag, "_busy1"}, {14'b0, ab1, bb1, bv1}, 32'h0);
  endtask

  task automatic rst_pulse();
    stim_t w;
    w = mk(1, 2, 32'hAAAA_5555, 2, 4, 1, 4);
    @(negedge clk);
    drive_raw(narrow(w), w);
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_low");
    @(posedge clk);
    #1 chk_zero("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    drive_raw(mk(0, 0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0));
    model_clear();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("A0", {16'b0, a0}, e.a);
        chk("B0", {16'b0, b0}, e.b);
        chk("A_busy0", {31'b0, ab0}, {31'b0, e.ab});
        chk("B_busy0", {31'b0, bb0}, {31'b0, e.bb});
        chk("busy_vec0", {24'b0, bv0}, {16'b0, e.bv});
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("A1", a1, e.a);
        chk("B1", b1, e.b);
        chk("A_busy1", {31'b0, ab1}, {31'b0, e.ab});
        chk("B_busy1", {31'b0, bb1}, {31'b0, e.bb});
        chk("busy_vec1", {16'b0, bv1}, {16'b0, e.bv});
      end
    end
  end

  initial begin : stimulus
    stim_t idle, s, t;
    idle = mk(0, 0, 0, 0, 0, 0, 0);
    model_clear();
    rst_n = 1'b0;
    drive_raw(idle, idle);
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 1; i < 8; i++) do_cycle(mk(1, i, 32'hFF00 + i, 0, 0, 0, 0), mk(1, i, 32'hFF00 + i, 0, 0, 0, 0));
    rst_pulse();
    for (int i = 0; i < 8; i++) do_cycle(mk(0, 0, 0, i, 7 - i, 0, 0), mk(0, 0, 0, i, 7 - i, 0, 0));

    for (int i = 1; i < 8; i++) do_cycle(mk(1, i, 32'hFF00 + i, 0, 0, 0, 0), mk(1, i, 32'hFF00 + i, 0, 0, 0, 0));
    do_cycle(idle, mk(1, 15, 32'hDEAD_BEEF, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) do_cycle(mk(0, 0, 0, i, 7 - i, 0, 0), mk(0, 0, 0, i, 7 - i, 0, 0));
    do_cycle(idle, mk(0, 0, 0, 15, 14, 0, 0));

    s = mk(1, 0, 32'hFFFF, 0, 0, 0, 0);
    do_cycle(s, s);
    s = mk(0, 0, 0, 0, 0, 0, 0);
    do_cycle(s, s);

    s = mk(1, 3, 32'h1234, 3, 3, 0, 0);
    do_cycle(s, s);
    s = mk(0, 0, 0, 3, 0, 0, 0);
    do_cycle(s, s);

    s = mk(0, 0, 0, 5, 5, 1, 5);
    do_cycle(s, s);
    s = mk(0, 0, 0, 5, 0, 0, 0);
    do_cycle(s, s);
    s = mk(1, 5, 32'h5555, 5, 5, 0, 0);
    do_cycle(s, s);
    s = mk(1, 5, 32'h6666, 5, 5, 1, 5);
    do_cycle(s, s);
    s = mk(0, 0, 0, 5, 5, 0, 0);
    do_cycle(s, s);

    for (int n = 0; n < 400; n++) begin
      if (n == 200) rst_pulse();
      s = mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom, $urandom_range(0, 15),
             $urandom_range(0, 15), ($urandom_range(0, 2) == 0), $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) s.rsa = s.rd;
      if ($urandom_range(0, 3) == 0) s.rsb = s.rd;
      if ($urandom_range(0, 4) == 0) s.rr = s.rd;
      t = mk($urandom_range(0, 1), $urandom_range(0, 15), $urandom, $urandom_range(0, 15),
             $urandom_range(0, 15), ($urandom_range(0, 2) == 0), $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) t.rsa = t.rd;
      if ($urandom_range(0, 4) == 0) t.rr = t.rd;
      do_cycle(s, t);
    end

    repeat (3) @(negedge clk);
    chk("drain0", q0.size(), 32'h0);
    chk("drain1", q1.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
